// File: rtl/divider_array_share_ctrl.sv
// divider_array_share_ctrl
// Shares one combinational 16/8 array divider core between two requesters.
// Round-robin arbitration, operand hold for SETTLE_CYCLES, divide-by-zero and
// quotient-overflow screening, valid/ready response, completion/error counters.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   reqX_valid/ready/n/d      request channels (X = 0,1); ready is combinational
//   div_n, div_d              operands driven to the divider core (registered)
//   div_q, div_r              results from the divider core
//   rsp_valid/ready/id/q/r/err response channel (err bit0 = /0, bit1 = overflow)
//   busy                      controller not idle
//   done_cnt, err_cnt         delivered responses / delivered erroneous responses
module divider_array_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_n,
    input  logic [7:0]  req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_n,
    input  logic [7:0]  req1_d,
    output logic [15:0] div_n,
    output logic [7:0]  div_d,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_q,
    output logic [7:0]  rsp_r,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic [15:0] done_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned EW = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DW-1:0]   d_q, d_d;
    logic            id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   r_q, r_d;
    logic [EW-1:0]   err_q, err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic [15:0]     done_cnt_q, done_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic            gnt0, gnt1;
    logic [NW-1:0]   acc_n;
    logic [DW-1:0]   acc_d;

    // Round-robin grant: on contention the port that did not win last time goes.
    always_comb begin
        gnt0 = (state_q == S_IDLE) && req0_valid && (!req1_valid || last_grant_q);
        gnt1 = (state_q == S_IDLE) && req1_valid && (!req0_valid || !last_grant_q);
        acc_n = gnt1 ? req1_n : req0_n;
        acc_d = gnt1 ? req1_d : req0_d;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        n_d          = n_q;
        d_d          = d_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        q_d          = q_q;
        r_d          = r_q;
        err_d        = err_q;
        done_cnt_d   = done_cnt_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    n_d          = acc_n;
                    d_d          = acc_d;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    if (acc_d == '0) begin
                        q_d     = '1;
                        r_d     = '1;
                        err_d   = 2'b01;
                        state_d = S_RESP;
                    end else if (acc_n[NW-1:DW] >= acc_d) begin
                        // Quotient would not fit in 8 bits.
                        q_d     = '1;
                        r_d     = '1;
                        err_d   = 2'b10;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CW'(SETTLE_CYCLES - 1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    err_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    if (err_q != '0) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            n_q          <= '0;
            d_q          <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            q_q          <= '0;
            r_q          <= '0;
            err_q        <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            n_q          <= n_d;
            d_q          <= d_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            q_q          <= q_d;
            r_q          <= r_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            done_cnt_q   <= done_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign div_n     = n_q;
    assign div_d     = d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_q     = q_q;
    assign rsp_r     = r_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_divider_array_share_ctrl.sv
// Bench for divider_array_share_ctrl with an exact divider core model attached.
module tb_divider_array_share_ctrl;

    localparam int unsigned S = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_n, req1_n;
    logic [7:0]  req0_d, req1_d;
    logic [15:0] div_n;
    logic [7:0]  div_d;
    logic [7:0]  div_q, div_r;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_q, rsp_r;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [15:0] done_cnt, err_cnt;

    int tests_run = 0;
    int failed    = 0;

    // Reference bookkeeping
    int m_done = 0;
    int m_err  = 0;

    always #5 clk = ~clk;

    divider_array_share_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
        .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
        .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    // Exact combinational divider core
    always_comb begin
        if (div_d == 8'd0) begin
            div_q = 8'hFF;
            div_r = 8'hFF;
        end else begin
            div_q = 8'(div_n / 16'(div_d));
            div_r = 8'(div_n % 16'(div_d));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected response for one request, from plain arithmetic.
    task automatic model(input logic [15:0] n, input logic [7:0] d,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic [1:0] err, output int lat);
        int quo;
        if (d == 8'd0) begin
            q = 8'hFF; r = 8'hFF; err = 2'b01; lat = 1;
        end else begin
            quo = int'(n) / int'(d);
            if (quo > 255) begin
                q = 8'hFF; r = 8'hFF; err = 2'b10; lat = 1;
            end else begin
                q = 8'(quo); r = 8'(int'(n) % int'(d)); err = 2'b00; lat = S + 1;
            end
        end
    endtask

    // Drives one request on a port, waits for the response and handshakes it.
    // Entered and left just after a falling edge.
    task automatic run_txn(input bit port, input logic [15:0] n, input logic [7:0] d,
                           output logic id, output logic [7:0] q, output logic [7:0] r,
                           output logic [1:0] err, output int lat,
                           output bit timeout, output bit unstable);
        int w;
        timeout = 0; unstable = 0; lat = 0; id = 0; q = 0; r = 0; err = 0;
        if (port) begin req1_valid = 1; req1_n = n; req1_d = d; end
        else      begin req0_valid = 1; req0_n = n; req0_d = d; end
        w = 0;
        #1;
        while (!(port ? req1_ready : req0_ready)) begin
            @(negedge clk); #1;
            w++;
            if (w > 50) begin
                timeout = 1; req0_valid = 0; req1_valid = 0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        req0_n = 16'($urandom); req0_d = 8'($urandom);
        req1_n = 16'($urandom); req1_d = 8'($urandom);
        lat = 1;
        while (!rsp_valid) begin
            if (div_n !== n || div_d !== d) unstable = 1;
            @(negedge clk);
            lat++;
            if (lat > 40) begin timeout = 1; return; end
        end
        id = rsp_id; q = rsp_q; r = rsp_r; err = rsp_err;
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_done = 0; m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        tests_run++;
        if ({rsp_valid, busy, rsp_id, rsp_q, rsp_r, rsp_err} !== 20'd0) begin
            failed++;
            $display("FAIL reset_rsp got v=%b b=%b id=%b q=%h r=%h e=%b required all 0",
                     rsp_valid, busy, rsp_id, rsp_q, rsp_r, rsp_err);
        end
        tests_run++;
        if ({div_n, div_d, done_cnt, err_cnt} !== 56'd0) begin
            failed++;
            $display("FAIL reset_regs got n=%h d=%h done=%h err=%h required 0",
                     div_n, div_d, done_cnt, err_cnt);
        end
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failed++;
            $display("FAIL reset_ready got %b%b required 00", req0_ready, req1_ready);
        end
    endtask

    task automatic test_directed();
        logic id; logic [7:0] q, r; logic [1:0] e; int lat; bit to, un;

        run_txn(0, 16'd1000, 8'd7, id, q, r, e, lat, to, un);
        m_done++;
        tests_run++;
        if (to || {id, q, r, e} !== {1'b0, 8'd142, 8'd6, 2'b00} || lat != 4) begin
            failed++;
            $display("FAIL dir_1000_7 got to=%0d id=%b q=%0d r=%0d e=%b lat=%0d required id=0 q=142 r=6 e=00 lat=4",
                     to, id, q, r, e, lat);
        end
        tests_run++;
        if (done_cnt !== 16'd1 || un) begin
            failed++;
            $display("FAIL dir_done_cnt got %0d unstable=%0d required 1/0", done_cnt, un);
        end

        run_txn(1, 16'h1234, 8'd0, id, q, r, e, lat, to, un);
        m_done++; m_err++;
        tests_run++;
        if (to || {id, q, r, e} !== {1'b1, 8'hFF, 8'hFF, 2'b01} || lat != 1) begin
            failed++;
            $display("FAIL dir_div0 got to=%0d id=%b q=%h r=%h e=%b lat=%0d required id=1 ff ff 01 lat=1",
                     to, id, q, r, e, lat);
        end
        tests_run++;
        if (err_cnt !== 16'd1) begin
            failed++;
            $display("FAIL dir_err_cnt got %0d required 1", err_cnt);
        end

        run_txn(0, 16'h0900, 8'd9, id, q, r, e, lat, to, un);
        m_done++; m_err++;
        tests_run++;
        if (to || {q, r, e} !== {8'hFF, 8'hFF, 2'b10} || lat != 1) begin
            failed++;
            $display("FAIL dir_ovf_boundary got q=%h r=%h e=%b lat=%0d required ff ff 10 lat=1", q, r, e, lat);
        end

        run_txn(0, 16'h08FF, 8'd9, id, q, r, e, lat, to, un);
        m_done++;
        tests_run++;
        if (to || {q, r, e} !== {8'd255, 8'd8, 2'b00} || lat != 4) begin
            failed++;
            $display("FAIL dir_max_quot got q=%0d r=%0d e=%b lat=%0d required 255 8 00 lat=4", q, r, e, lat);
        end
    endtask

    task automatic test_random();
        logic id; logic [7:0] q, r; logic [1:0] e; int lat; bit to, un;
        logic [7:0] xq, xr; logic [1:0] xe; int xlat;
        logic [15:0] n; logic [7:0] d; bit port;
        for (int i = 0; i < 24; i++) begin
            port = 1'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            n = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
            run_txn(port, n, d, id, q, r, e, lat, to, un);
            model(n, d, xq, xr, xe, xlat);
            m_done++;
            if (xe != 2'b00) m_err++;
            tests_run++;
            if (to || id !== port || q !== xq || r !== xr || e !== xe || lat != xlat) begin
                failed++;
                $display("FAIL rand_%0d n=%h d=%h got to=%0d id=%b q=%h r=%h e=%b lat=%0d required id=%b q=%h r=%h e=%b lat=%0d",
                         i, n, d, to, id, q, r, e, lat, port, xq, xr, xe, xlat);
            end
            tests_run++;
            if (un || done_cnt !== 16'(m_done) || err_cnt !== 16'(m_err)) begin
                failed++;
                $display("FAIL rand_cnt_%0d got unstable=%0d done=%0d err=%0d required 0/%0d/%0d",
                         i, un, done_cnt, err_cnt, m_done, m_err);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        req0_valid = 1; req0_n = 16'd1000; req0_d = 8'd7;
        w = 0; #1;
        while (!req0_ready && w < 50) begin @(negedge clk); #1; w++; end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1; req1_n = 16'd500; req1_d = 8'd3;
        w = 0;
        while (!rsp_valid && w < 40) begin @(negedge clk); w++; end
        tests_run++;
        if (!rsp_valid) begin
            failed++;
            $display("FAIL bp_no_response got rsp_valid=0 required 1");
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, req0_ready, req1_ready} !==
                {1'b1, 1'b0, 8'd142, 8'd6, 2'b00, 2'b00}) begin
                failed++;
                $display("FAIL bp_hold_%0d got v=%b id=%b q=%0d r=%0d e=%b rdy=%b%b required 1 0 142 6 00 00",
                         c, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failed++;
            $display("FAIL bp_ready_at_handshake got %b%b required 00", req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        m_done++;
        #1;
        tests_run++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== 16'(m_done) ||
            (req0_ready ^ req1_ready) !== 1'b1) begin
            failed++;
            $display("FAIL bp_after_handshake got busy=%b v=%b done=%0d rdy=%b%b required 0 0 %0d one-hot",
                     busy, rsp_valid, done_cnt, req0_ready, req1_ready, m_done);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_contention();
        int acc, cyc, exp_port;
        do_reset();
        rsp_ready = 1;
        req0_d = 8'd13; req0_n = 16'd2000;
        req1_d = 8'd200; req1_n = 16'd40000;
        req0_valid = 1; req1_valid = 1;
        acc = 0; cyc = 0; exp_port = 0;
        while (acc < 4 && cyc < 200) begin
            #1;
            if (!busy) begin
                tests_run++;
                if ((req0_ready + req1_ready) != 1 || req1_ready !== 1'(exp_port)) begin
                    failed++;
                    $display("FAIL cont_grant_%0d got rdy=%b%b required port %0d only",
                             acc, req1_ready, req0_ready, exp_port);
                end
                acc++;
                exp_port = 1 - exp_port;
            end else begin
                tests_run++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    failed++;
                    $display("FAIL cont_busy_ready got %b%b required 00", req0_ready, req1_ready);
                end
            end
            if (acc < 4) @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        cyc = 0;
        while (busy && cyc < 40) begin @(negedge clk); cyc++; end
        m_done += 4;
        rsp_ready = 0;
        tests_run++;
        if (acc != 4 || done_cnt !== 16'd4 || err_cnt !== 16'd0) begin
            failed++;
            $display("FAIL cont_totals got accepts=%0d done=%0d err=%0d required 4 4 0", acc, done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        req0_valid = 1; req0_n = 16'd1000; req0_d = 8'd7;
        w = 0; #1;
        while (!req0_ready && w < 50) begin @(negedge clk); #1; w++; end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        #2;
        rst = 1;
        #1;
        tests_run++;
        if ({busy, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_n, div_d,
             done_cnt, err_cnt, req0_ready, req1_ready} !== 78'd0) begin
            failed++;
            $display("FAIL midrst_outputs got busy=%b v=%b q=%h r=%h e=%b n=%h d=%h done=%0d err=%0d",
                     busy, rsp_valid, rsp_q, rsp_r, rsp_err, div_n, div_d, done_cnt, err_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_done = 0; m_err = 0;
        repeat (S + 3) @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || done_cnt !== 16'd0) begin
            failed++;
            $display("FAIL midrst_dropped got v=%b done=%0d required 0 0", rsp_valid, done_cnt);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failed++;
            $display("FAIL midrst_first_grant got rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        rst = 1; rsp_ready = 0;
        req0_valid = 0; req1_valid = 0;
        req0_n = 0; req0_d = 0; req1_n = 0; req1_d = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_contention();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/divider_array_share_ctrl.md
# divider_array_share_ctrl

Sequential controller that shares one combinational 16-by-8 array divider core between two requesters. The core may be the exact or an approximate variant; this block sees only its ports n[15:0], d[7:0], q[7:0] and r[7:0]. The controller arbitrates round-robin, holds operands stable on the core for a programmable settle window, screens out divide-by-zero and quotient-overflow, and returns results over a valid/ready response channel. It sits between the requester logic and the divider core instance, and it also keeps completion and error counters.

## Interface
- SETTLE_CYCLES, 3: cycles the core operands are held before the result is sampled. Legal range 1..15.
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid / req1_valid  in  1  request present on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_n / req1_n  in  16  dividend.
- req0_d / req1_d  in  8  divisor.
- div_n  out  16  dividend driven to the core.
- div_d  out  8  divisor driven to the core.
- div_q  in  8  quotient returned by the core.
- div_r  in  8  remainder returned by the core.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index of the response.
- rsp_q  out  8  quotient.
- rsp_r  out  8  remainder.
- rsp_err  out  2  bit0 = divide-by-zero, bit1 = overflow (n[15:8] >= d, d != 0).
- busy  out  1  high when the FSM is not in IDLE.
- done_cnt  out  16  responses delivered; wraps at 0xFFFF -> 0.
- err_cnt  out  16  delivered responses with rsp_err != 0; wraps.

## Operation
- FSM has three states: IDLE, SETTLE, RESP.
- Arbitration in IDLE:
  - Exactly one ready is asserted, combinationally.
  - If only one valid is high, that port is granted.
  - If both are high, the port != last_grant is granted.
  - last_grant resets to 1, so port 0 wins the first contention.
  - With no valid, no ready is asserted.
- Accept happens when readyX & validX:
  - n, d and id are latched; div_n and div_d update from these registers; last_grant is updated.
  - d == 0: go to RESP with q=8'hFF, r=8'hFF, err=2'b01. No settle.
  - n[15:8] >= d: go to RESP with q=8'hFF, r=8'hFF, err=2'b10. No settle.
  - Otherwise: go to SETTLE with the counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - Counter decrements each cycle.
  - In the cycle the counter is 0, div_q and div_r are registered into rsp_q and rsp_r, err=0, and the FSM goes to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q, rsp_r and rsp_err are held stable.
  - On rsp_valid & rsp_ready: done_cnt increments, err_cnt increments if err != 0, and the FSM goes to IDLE.
  - No request is accepted in that same cycle.
- div_n and div_d keep the last operands after completion; they change only on accept.
- Asynchronous reset returns the block to IDLE and clears every register to 0, except last_grant, which resets to 1. This applies to every output (rsp_*, busy, counters, div_n, div_d).
- Reset in any state drops the in-flight transaction; no response is produced for it.

## Timing
- Accept occurs at edge k.
- Normal path: the FSM is in SETTLE for cycles k+1..k+SETTLE_CYCLES, and rsp_valid rises in cycle k+SETTLE_CYCLES+1.
- Error path: rsp_valid rises in cycle k+1.
- Minimum period per transaction, with rsp_ready tied high: SETTLE_CYCLES+2 cycles normal, 2 cycles error.
- div_n and div_d are registered outputs and are stable for the full settle window.
- The core path must close within SETTLE_CYCLES clock periods; this is a multicycle constraint.
- reqX_ready depends only on state, last_grant and the valids. It never depends on rsp_ready.
- A requester may hold valid while waiting. The operands it presents at the accept edge are the operands that are used.

## Test plan
- Exact core, SETTLE_CYCLES=3, req0 n=1000 d=7, accepted at edge k -> rsp_valid in cycle k+4 with id=0, q=142, r=6, err=0; done_cnt=1.
- req1 n=0x1234 d=0 -> rsp_valid in cycle k+1 with id=1, q=0xFF, r=0xFF, err=01; err_cnt=1.
- req0 n=0x0900 d=9 -> err=10, q=0xFF. Then n=0x08FF d=9 -> err=0, q=255, r=8.
- Both valids held high for 4 transactions -> grant order 0,1,0,1, with exactly one ready per accept.
- rsp_ready held low for 5 cycles in RESP -> response stable and both readys low throughout; accept only after the cycle following the response handshake.
- rst asserted mid-SETTLE (between clock edges) -> all outputs 0 immediately, busy=0, counters unchanged from 0; after release, req0 wins the next contention.
